// File: rtl/fp16_pkg.sv
// Shared constants and state type for the FP16 vector packer.
package fp16_pkg;

    localparam int unsigned FP_W          = 16;
    localparam int unsigned N_ELEM        = 64;
    localparam logic [15:0] FP16_POS_ZERO = 16'h0000;

    typedef enum logic {
        StFill,
        StSend
    } state_e;

endpackage

// File: rtl/fp16_vec64_pack.sv
// Packs a stream of FP16 elements into one N_ELEM-lane vector for an adder tree.
// Single buffer: the vector is held until the downstream handshake, then cleared.
module fp16_vec64_pack #(
    parameter int unsigned N_ELEM = fp16_pkg::N_ELEM,
    parameter int unsigned FP_W   = fp16_pkg::FP_W
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [FP_W-1:0]                  in_data,
    input  logic                             in_last,
    output logic [N_ELEM*FP_W-1:0]           x,
    output logic                             x_valid,
    input  logic                             x_ready,
    output logic [$clog2(N_ELEM+1)-1:0]      vec_len
);
    import fp16_pkg::*;

    localparam int unsigned CntW = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
    localparam int unsigned LenW = $clog2(N_ELEM + 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            in_ready_q, in_ready_d;
    logic            x_valid_q, x_valid_d;
    logic [LenW-1:0] vec_len_q, vec_len_d;
    logic [FP_W-1:0] lane_q [N_ELEM];
    logic [N_ELEM-1:0] lane_we;
    logic            lane_clr;
    logic            accept, close, hs;

    // in_ready_q is only ever set in StFill, so it also gates acceptance.
    assign accept = in_valid && in_ready_q;
    assign close  = accept && (in_last || (cnt_q == CntW'(N_ELEM - 1)));
    assign hs     = x_valid_q && x_ready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        in_ready_d = in_ready_q;
        x_valid_d  = x_valid_q;
        vec_len_d  = vec_len_q;
        lane_clr   = 1'b0;
        case (state_q)
            StFill: begin
                in_ready_d = 1'b1;
                if (close) begin
                    state_d    = StSend;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    x_valid_d  = 1'b1;
                    vec_len_d  = LenW'(cnt_q) + LenW'(1);
                end else if (accept) begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StSend: begin
                in_ready_d = 1'b0;
                if (hs) begin
                    state_d    = StFill;
                    lane_clr   = 1'b1;
                    cnt_d      = '0;
                    in_ready_d = 1'b1;
                    x_valid_d  = 1'b0;
                    vec_len_d  = '0;
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StFill;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            x_valid_q  <= 1'b0;
            vec_len_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            in_ready_q <= in_ready_d;
            x_valid_q  <= x_valid_d;
            vec_len_q  <= vec_len_d;
        end
    end

    for (genvar k = 0; k < N_ELEM; k++) begin : g_lane
        assign lane_we[k]            = accept && (cnt_q == CntW'(k));
        assign x[k*FP_W +: FP_W]     = lane_q[k];
    end

    // Unwritten lanes stay +0.0 so a short vector sums correctly downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < N_ELEM; k++) begin
                lane_q[k] <= FP_W'(FP16_POS_ZERO);
            end
        end else begin
            for (int unsigned k = 0; k < N_ELEM; k++) begin
                if (lane_clr) begin
                    lane_q[k] <= FP_W'(FP16_POS_ZERO);
                end else if (lane_we[k]) begin
                    lane_q[k] <= in_data;
                end
            end
        end
    end

    assign in_ready = in_ready_q;
    assign x_valid  = x_valid_q;
    assign vec_len  = vec_len_q;

endmodule

// File: tb/tb_fp16_vec64_pack.sv
// Directed self-checking bench for fp16_vec64_pack with a real-valued adder-tree model.
module tb_fp16_vec64_pack;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, in_last, x_valid, x_ready;
    logic [15:0]   in_data;
    logic [1023:0] x;
    logic [6:0]    vec_len;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_lane [64];
    int          exp_cnt;

    typedef struct {
        int          n;
        logic [15:0] d0;
        logic [15:0] step;
        bit          last;
        int          exp_len;
        logic [15:0] exp_sum;
    } vec_t;

    vec_t tbl [4];

    fp16_vec64_pack dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .x        (x),
        .x_valid  (x_valid),
        .x_ready  (x_ready),
        .vec_len  (vec_len)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic real fp16_to_real(input logic [15:0] h);
        int  e = int'(h[14:10]);
        real m = real'(h[9:0]);
        real v;
        if (e == 0) v = m * (2.0 ** (-24));
        else        v = (1.0 + m / 1024.0) * (2.0 ** (e - 15));
        return h[15] ? -v : v;
    endfunction

    function automatic logic [15:0] real_to_fp16(input real v_in);
        real v = v_in;
        int  e = 0;
        int  mant;
        if (v == 0.0) return 16'h0000;
        while (v >= 2.0) begin v = v / 2.0; e++; end
        while (v < 1.0)  begin v = v * 2.0; e--; end
        mant = int'((v - 1.0) * 1024.0);
        return {1'b0, 5'(e + 15), 10'(mant)};
    endfunction

    function automatic logic [15:0] adder_tree_sum();
        real s = 0.0;
        for (int k = 0; k < 64; k++) s += fp16_to_real(x[k*16 +: 16]);
        return real_to_fp16(s);
    endfunction

    function automatic int lane_mismatches();
        int bad = 0;
        for (int k = 0; k < 64; k++) begin
            if (x[k*16 +: 16] !== ((k < exp_cnt) ? exp_lane[k] : 16'h0000)) bad++;
        end
        return bad;
    endfunction

    task automatic model_clear();
        exp_cnt = 0;
        for (int k = 0; k < 64; k++) exp_lane[k] = 16'h0000;
    endtask

    // Offers one element and returns just after the edge that accepts it.
    task automatic push(input logic [15:0] d, input bit last, input int gap);
        int t = 0;
        repeat (gap) step();
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && t < 300) begin
            step();
            t++;
        end
        if (t >= 300) begin
            check("accept_timeout", 64'd0, 64'd1);
        end else begin
            step();
            if (exp_cnt < 64) exp_lane[exp_cnt] = d;
            exp_cnt++;
        end
        // Garbage while idle must be ignored.
        in_valid = 1'b0;
        in_data  = 16'hDEAD;
        in_last  = 1'b1;
    endtask

    task automatic check_send(input string name, input int len);
        check({name, "_x_valid"}, 64'(x_valid), 64'd1);
        check({name, "_vec_len"}, 64'(vec_len), 64'(len));
        check({name, "_lanes_bad"}, 64'(lane_mismatches()), 64'd0);
        check({name, "_in_ready"}, 64'(in_ready), 64'd0);
    endtask

    task automatic handshake(input string name);
        x_ready = 1'b1;
        step();
        x_ready = 1'b0;
        model_clear();
        check({name, "_hs_x_valid"}, 64'(x_valid), 64'd0);
        check({name, "_hs_in_ready"}, 64'(in_ready), 64'd1);
        check({name, "_hs_x_zero"}, 64'(x == '0), 64'd1);
    endtask

    initial begin
        tbl[0] = '{n: 64, d0: 16'h3C00, step: 16'h0000, last: 1'b0, exp_len: 64, exp_sum: 16'h5400};
        tbl[1] = '{n: 3,  d0: 16'h4000, step: 16'h0200, last: 1'b1, exp_len: 3,  exp_sum: 16'h4880};
        tbl[2] = '{n: 1,  d0: 16'h3C00, step: 16'h0000, last: 1'b1, exp_len: 1,  exp_sum: 16'h3C00};
        tbl[3] = '{n: 64, d0: 16'h3800, step: 16'h0000, last: 1'b1, exp_len: 64, exp_sum: 16'h5000};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 16'h0000;
        in_last  = 1'b0;
        x_ready  = 1'b0;
        model_clear();

        #12;
        check("rst_x_valid", 64'(x_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_vec_len", 64'(vec_len), 64'd0);
        check("rst_x_zero", 64'(x == '0), 64'd1);
        #10 rst_n = 1'b1;
        #1 check("rst_release_in_ready_low", 64'(in_ready), 64'd0);
        step();
        check("rst_release_in_ready_high", 64'(in_ready), 64'd1);

        for (int r = 0; r < 4; r++) begin
            string nm = $sformatf("vec%0d", r);
            for (int j = 0; j < tbl[r].n; j++) begin
                if (j == tbl[r].n - 1) check({nm, "_pre_x_valid"}, 64'(x_valid), 64'd0);
                push(16'(tbl[r].d0 + j * tbl[r].step), tbl[r].last && (j == tbl[r].n - 1), 0);
            end
            check_send(nm, tbl[r].exp_len);
            check({nm, "_sum"}, 64'(adder_tree_sum()), 64'(tbl[r].exp_sum));
            step();
            step();
            check({nm, "_held_in_ready"}, 64'(in_ready), 64'd0);
            check({nm, "_held_x_valid"}, 64'(x_valid), 64'd1);
            handshake(nm);
        end

        // Stall: x_ready low for 10 cycles, upstream keeps offering.
        for (int j = 0; j < 5; j++) push(16'h4500 + 16'(j), j == 4, 0);
        in_valid = 1'b1;
        in_data  = 16'h7BFF;
        for (int c = 0; c < 10; c++) begin
            check_send($sformatf("stall%0d", c), 5);
            step();
        end
        in_valid = 1'b0;
        handshake("stall");

        // 130 elements, no in_last, ready tied high.
        x_ready = 1'b1;
        for (int j = 0; j < 130; j++) begin
            push(16'h1000 + 16'(j), 1'b0, int'($urandom_range(0, 2)));
            if (j % 64 == 63) begin
                check_send($sformatf("stream_vec%0d", j / 64), 64);
                model_clear();
            end
        end
        x_ready = 1'b0;
        push(16'h2000, 1'b1, 0);
        check_send("stream_tail", 3);
        check("stream_tail_lane0", 64'(x[15:0]), 64'h1080);
        handshake("stream_tail");

        // Reset mid-vector.
        for (int j = 0; j < 20; j++) push(16'h3000 + 16'(j), 1'b0, 0);
        #3 rst_n = 1'b0;
        #1;
        check("rstmid_x_valid", 64'(x_valid), 64'd0);
        check("rstmid_x_zero", 64'(x == '0), 64'd1);
        check("rstmid_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1 check("rstmid_release_low", 64'(in_ready), 64'd0);
        step();
        check("rstmid_release_high", 64'(in_ready), 64'd1);
        model_clear();
        push(16'h5A00, 1'b0, 0);
        push(16'h5A01, 1'b1, 0);
        check_send("rstmid_next", 2);
        handshake("rstmid_next");

        // Reset while holding a vector.
        for (int j = 0; j < 3; j++) push(16'h2200 + 16'(j), j == 2, 0);
        check_send("rstsend", 3);
        #3 rst_n = 1'b0;
        #1;
        check("rstsend_x_valid", 64'(x_valid), 64'd0);
        check("rstsend_x_zero", 64'(x == '0), 64'd1);
        @(posedge clk);
        #2 rst_n = 1'b1;
        model_clear();
        step();
        step();
        check("rstsend_no_output", 64'(x_valid), 64'd0);
        check("rstsend_in_ready", 64'(in_ready), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp16_vec64_pack.md
FP16_VEC64_PACK -- requirements
Module: fp16_vec64_pack

Interface
REQ-001 SHALL have parameter N_ELEM, default 64, the number of FP16 lanes per output vector.
REQ-002 SHALL have parameter FP_W, default 16, the element width in bits.
REQ-003 SHALL have input clk, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have input rst_n, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have input in_valid, 1 bit: the upstream element is valid.
REQ-006 SHALL have output in_ready, 1 bit: the block accepts an element this cycle.
REQ-007 SHALL have input in_data, FP_W bits: the FP16 element.
REQ-008 SHALL have input in_last, 1 bit: the element closes the current vector early.
REQ-009 SHALL have output x, N_ELEM*FP_W bits: the packed vector, lane k at x[k*FP_W +: FP_W].
REQ-010 SHALL have output x_valid, 1 bit: the packed vector is valid.
REQ-011 SHALL have input x_ready, 1 bit: the downstream 64-input adder tree accepts the vector (its all-lanes ready).
REQ-012 SHALL have output vec_len, 7 bits: the number of real elements in x (1..64), valid while x_valid is high.

Function
REQ-013 SHALL use two states: FILL (accepting elements) and SEND (holding the vector).
REQ-014 SHALL drive in_ready=1 only in FILL; in_ready is registered and SHALL be 0 in SEND.
REQ-015 SHALL treat an input transfer as in_valid&&in_ready on a rising edge; element j of the vector is written to lane j, where j is the lane counter (0..N_ELEM-1).
REQ-016 SHALL go FILL->SEND on the edge that accepts lane N_ELEM-1, or that accepts any element with in_last=1; x_valid SHALL be high on the next cycle (1-cycle latency).
REQ-017 SHALL leave lanes not written before in_last at +0.0 (16'h0000), so partial vectors sum correctly.
REQ-018 SHALL set vec_len to the number of accepted elements, including the closing one; in_last on lane N_ELEM-1 gives vec_len=64.
REQ-019 SHALL hold x, x_valid and vec_len stable in SEND until x_valid&&x_ready.
REQ-020 SHALL, on the edge where x_valid&&x_ready, return to FILL: clear all lanes to 0, clear the counter, set in_ready=1 and x_valid=0.
REQ-021 SHALL NOT drop x_valid without a handshake; x_ready high outside SEND SHALL have no effect.
REQ-022 SHALL, for a 65th element with no in_last, start a new vector at lane 0 (in_last is optional).
REQ-023 SHALL give a throughput of at most one vector per N_ELEM+2 cycles; this single-buffer limit is accepted.
REQ-024 SHALL ignore in_data and in_last when in_valid=0 or in_ready=0.

Reset
REQ-025 SHALL, while rst_n=0 (asynchronous), force: state=FILL, counter=0, all lanes of x=0, x_valid=0, vec_len=0, in_ready=0.
REQ-026 SHALL raise in_ready on the first rising edge after rst_n deasserts.
REQ-027 SHALL, on reset mid-vector or mid-SEND, discard the partial or held vector with no output.

Structure
REQ-028 SHALL place FP_W, N_ELEM, FP16_POS_ZERO (16'h0000) and the FILL/SEND state enum in shared package fp16_pkg.
REQ-029 SHALL have no sub-module: one FSM, one counter and one lane register file with per-lane write enables.

Verification
REQ-030 SHALL cover: 64 back-to-back elements 16'h3C00 (1.0) -> x_valid 1 cycle after the 64th accept; all lanes 16'h3C00; vec_len=64; in_ready=0 until the handshake.
REQ-031 SHALL cover: 3 elements 16'h4000, 16'h4200, 16'h4400 with in_last on the third -> lanes 0..2 hold those values, lanes 3..63 = 16'h0000, vec_len=3.
REQ-032 SHALL cover: x_ready held 0 for 10 cycles in SEND -> x, x_valid and vec_len stable and in_ready=0 throughout; on x_ready=1, one handshake then in_ready=1 next cycle.
REQ-033 SHALL cover: 130 elements with no in_last, random in_valid gaps, x_ready tied 1 -> two full vectors with correct lane order, then 2 elements pending in FILL.
REQ-034 SHALL cover: rst_n pulsed low after 20 elements -> x_valid=0 and x=0 immediately; in_ready=0 during reset, 1 one edge after release; the next vector starts at lane 0.
REQ-035 SHALL cover: a vector of all 16'h3C00 fed to the downstream 64-input adder -> sum 16'h5400 (64.0).
